if_fetch_unit: RTL and testbench

Fetch stage of the LC-3b pipeline, directly upstream of the IF/ID stage register.
- Owns the PC and issues instruction-memory reads using a read/resp handshake.
- Drives the IF/ID register's load and flush inputs, plus the instruction and PC+2 it captures.
- Absorbs downstream stalls with a one-entry hold buffer.
- On a branch redirect, drops any in-flight read without corrupting the memory handshake.

---
 rtl/if_fetch_unit_pkg.sv | 14 +
 rtl/if_fetch_unit_if.sv | 12 +
 rtl/if_fetch_unit_hold_buffer.sv | 28 ++
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - LC-3b shared types for the fetch stage
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } lc3b_fetch_state;

  localparam lc3b_word LC3B_PC_INCR = 16'd2;

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory read/resp bus between fetch and memory
interface if_fetch_unit_if import lc3b_types::*; ();

  logic     imem_read;
  lc3b_word imem_address;
  lc3b_word imem_rdata;
  logic     imem_resp;

  modport master (output imem_read, output imem_address, input imem_rdata, input imem_resp);
  modport slave  (input imem_read, input imem_address, output imem_rdata, output imem_resp);

endinterface

// File: rtl/if_fetch_unit_hold_buffer.sv
// rtl/if_fetch_unit_hold_buffer.sv - one-entry instruction/PC+2 holding register
module if_hold_buffer import lc3b_types::*; (
  input  logic     clk,
  input  logic     reset_sig,
  input  logic     capture,
  input  logic     clear,
  input  lc3b_word instr_in,
  input  lc3b_word pc2_in,
  output lc3b_word instr,
  output lc3b_word pc2,
  output logic     valid
);

  always_ff @(posedge clk) begin
    if (reset_sig) begin
      instr <= '0;
      pc2   <= '0;
      valid <= 1'b0;
    end else if (capture) begin
      instr <= instr_in;
      pc2   <= pc2_in;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - LC-3b fetch stage feeding IF/ID; IF_FETCH_PERF_EN adds perf counters
module if_fetch_unit import lc3b_types::*; #(
  parameter lc3b_word RESET_PC  = 16'h0000,
  parameter int       CNT_WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset_sig,
  input  logic     stall,
  input  logic     branch_taken,
  input  lc3b_word branch_target,
  if_fetch_unit_if.master imem,
  output lc3b_word instruction_out,
  output lc3b_word pc_plus2_out,
  output logic     load_if,
  output logic     flush_if
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] fetch_count_out,
  output logic [CNT_WIDTH-1:0] stall_count_out
`endif
);

  lc3b_fetch_state state, state_n;
  lc3b_word pc, pc_n, pc_plus2, discard_addr, discard_n;
  lc3b_word hold_instr, hold_pc2;
  logic hold_valid, hold_capture, hold_clear;

  assign pc_plus2 = pc + LC3B_PC_INCR;

  if_hold_buffer u_hold (
    .clk       (clk),
    .reset_sig (reset_sig),
    .capture   (hold_capture),
    .clear     (hold_clear),
    .instr_in  (imem.imem_rdata),
    .pc2_in    (pc_plus2),
    .instr     (hold_instr),
    .pc2       (hold_pc2),
    .valid     (hold_valid)
  );

  always_comb begin
    imem.imem_read    = 1'b0;
    imem.imem_address = pc;
    instruction_out   = imem.imem_rdata;
    pc_plus2_out      = pc_plus2;
    load_if           = !stall;
    flush_if          = 1'b1;
    hold_capture      = 1'b0;
    hold_clear        = 1'b0;
    state_n           = state;
    pc_n              = pc;
    discard_n         = discard_addr;

    case (state)
      FETCH: begin
        imem.imem_read = 1'b1;
        if (imem.imem_resp) begin
          pc_n = pc_plus2;
          if (stall) begin
            hold_capture = 1'b1;
            state_n      = HOLD;
          end else begin
            load_if  = 1'b1;
            flush_if = 1'b0;
          end
        end
      end
      HOLD: begin
        instruction_out = hold_instr;
        pc_plus2_out    = hold_pc2;
        if (!stall) begin
          load_if    = 1'b1;
          flush_if   = !hold_valid;
          hold_clear = 1'b1;
          state_n    = FETCH;
        end
      end
      DISCARD: begin
        imem.imem_read    = 1'b1;
        imem.imem_address = discard_addr;
        if (imem.imem_resp) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase

    // Redirect forces a bubble even under stall; an in-flight read must still complete at its old address.
    if (branch_taken) begin
      load_if      = 1'b1;
      flush_if     = 1'b1;
      pc_n         = branch_target & 16'hFFFE;
      hold_capture = 1'b0;
      hold_clear   = 1'b1;
      case (state)
        FETCH: begin
          if (imem.imem_resp) begin
            state_n = FETCH;
          end else begin
            discard_n = pc;
            state_n   = DISCARD;
          end
        end
        DISCARD: state_n = imem.imem_resp ? FETCH : DISCARD;
        default: state_n = FETCH;
      endcase
    end

    if (reset_sig) begin
      imem.imem_read = 1'b0;
      load_if        = 1'b1;
      flush_if       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sig) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      discard_addr <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      discard_addr <= discard_n;
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset_sig) begin
      fetch_count_out <= '0;
      stall_count_out <= '0;
    end else begin
      if (load_if && !flush_if && fetch_count_out != '1)
        fetch_count_out <= fetch_count_out + 1'b1;
      if (stall && (state == HOLD || (state == FETCH && imem.imem_resp)) && stall_count_out != '1)
        stall_count_out <= stall_count_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset_sig, stall, branch_taken;
  lc3b_word branch_target, instruction_out, pc_plus2_out;
  logic     load_if, flush_if;
  int       checks = 0;
  int       errors = 0;

  if_fetch_unit_if imem ();

`ifdef IF_FETCH_PERF_EN
  logic [15:0] fetch_count_out, stall_count_out;
`endif

  if_fetch_unit #(.RESET_PC(16'h0000), .CNT_WIDTH(16)) dut (
    .clk             (clk),
    .reset_sig       (reset_sig),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem            (imem.master),
    .instruction_out (instruction_out),
    .pc_plus2_out    (pc_plus2_out),
    .load_if         (load_if),
    .flush_if        (flush_if)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_count_out (fetch_count_out),
    .stall_count_out (stall_count_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic br, input lc3b_word tgt,
                       input logic resp, input lc3b_word rdata);
    reset_sig          = rst;
    stall              = stl;
    branch_taken       = br;
    branch_target      = tgt;
    imem.imem_resp     = resp;
    imem.imem_rdata    = rdata;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus outputs: read, address, load, flush
  task automatic chk_bus(input string tag, input logic rd, input lc3b_word addr,
                         input logic ld, input logic fl);
    chk({tag, "_read"}, {31'd0, imem.imem_read}, {31'd0, rd});
    if (rd) chk({tag, "_addr"}, {16'd0, imem.imem_address}, {16'd0, addr});
    chk({tag, "_load"}, {31'd0, load_if}, {31'd0, ld});
    chk({tag, "_flush"}, {31'd0, flush_if}, {31'd0, fl});
  endtask

  task automatic chk_data(input string tag, input lc3b_word ins, input lc3b_word pc2);
    chk({tag, "_instr"}, {16'd0, instruction_out}, {16'd0, ins});
    chk({tag, "_pc2"}, {16'd0, pc_plus2_out}, {16'd0, pc2});
  endtask

  initial begin
    // Reset
    drive(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk_bus("rst", 0, 16'h0000, 1, 1);
    step();
`ifdef IF_FETCH_PERF_EN
    chk("rst_fcnt", {16'd0, fetch_count_out}, 32'd0);
    chk("rst_scnt", {16'd0, stall_count_out}, 32'd0);
`endif

    // Scenario 1: three fetches, each answered on the second cycle
    drive(0, 0, 0, 16'h0000, 0, 16'h0000); chk_bus("s1_w0", 1, 16'h0000, 1, 1); step();
    drive(0, 0, 0, 16'h0000, 1, 16'hA000); chk_bus("s1_r0", 1, 16'h0000, 1, 0);
    chk_data("s1_r0", 16'hA000, 16'h0002); step();
    drive(0, 0, 0, 16'h0000, 0, 16'h0000); chk_bus("s1_w1", 1, 16'h0002, 1, 1); step();
    drive(0, 0, 0, 16'h0000, 1, 16'hA002); chk_bus("s1_r1", 1, 16'h0002, 1, 0);
    chk_data("s1_r1", 16'hA002, 16'h0004); step();
    drive(0, 0, 0, 16'h0000, 0, 16'h0000); chk_bus("s1_w2", 1, 16'h0004, 1, 1); step();
    drive(0, 0, 0, 16'h0000, 1, 16'hA004); chk_bus("s1_r2", 1, 16'h0004, 1, 0);
    chk_data("s1_r2", 16'hA004, 16'h0006); step();
`ifdef IF_FETCH_PERF_EN
    chk("s1_fcnt", {16'd0, fetch_count_out}, 32'd3);
`endif

    // Scenario 2: stall on the response at 0006, held three cycles
    drive(0, 1, 0, 16'h0000, 1, 16'h1234); chk_bus("s2_cap", 1, 16'h0006, 0, 1); step();
    drive(0, 1, 0, 16'h0000, 0, 16'h0000); chk_bus("s2_h1", 0, 16'h0000, 0, 1); step();
    drive(0, 1, 0, 16'h0000, 1, 16'hBEEF); chk_bus("s2_h2", 0, 16'h0000, 0, 1);
    chk_data("s2_h2", 16'h1234, 16'h0008); step();
    drive(0, 0, 0, 16'h0000, 0, 16'h0000); chk_bus("s2_rel", 0, 16'h0000, 1, 0);
    chk_data("s2_rel", 16'h1234, 16'h0008); step();

    // Scenario 3: redirect to 0101 while the read at 0008 is pending
    drive(0, 0, 1, 16'h0101, 0, 16'h0000); chk_bus("s3_br", 1, 16'h0008, 1, 1); step();
    drive(0, 0, 0, 16'h0000, 0, 16'h0000); chk_bus("s3_d0", 1, 16'h0008, 1, 1); step();
    drive(0, 0, 0, 16'h0000, 1, 16'hDEAD); chk_bus("s3_d1", 1, 16'h0008, 1, 1); step();
    drive(0, 0, 0, 16'h0000, 1, 16'hC100); chk_bus("s3_tgt", 1, 16'h0100, 1, 0);
    chk_data("s3_tgt", 16'hC100, 16'h0102); step();

    // Scenario 4: redirect together with stall while in HOLD
    drive(0, 1, 0, 16'h0000, 1, 16'h5555); chk_bus("s4_cap", 1, 16'h0102, 0, 1); step();
    drive(0, 1, 1, 16'hFFFE, 0, 16'h0000); chk_bus("s4_br", 0, 16'h0000, 1, 1); step();

    // Scenario 5: fetch at FFFE wraps PC+2 to 0000
    drive(0, 0, 0, 16'h0000, 1, 16'h7777); chk_bus("s5_r", 1, 16'hFFFE, 1, 0);
    chk_data("s5_r", 16'h7777, 16'h0000); step();
    drive(0, 0, 0, 16'h0000, 1, 16'h8888); chk_bus("s5_wrap", 1, 16'h0000, 1, 0);
    chk_data("s5_wrap", 16'h8888, 16'h0002); step();

    // Scenario 6: reset while in DISCARD (discard address 0002)
    drive(0, 0, 1, 16'h0200, 0, 16'h0000); chk_bus("s6_br", 1, 16'h0002, 1, 1); step();
    drive(0, 0, 0, 16'h0000, 0, 16'h0000); chk_bus("s6_disc", 1, 16'h0002, 1, 1);
    drive(1, 0, 0, 16'h0000, 0, 16'h0000); chk_bus("s6_rst", 0, 16'h0000, 1, 1); step();
`ifdef IF_FETCH_PERF_EN
    chk("s6_fcnt", {16'd0, fetch_count_out}, 32'd0);
    chk("s6_scnt", {16'd0, stall_count_out}, 32'd0);
`endif
    drive(0, 0, 0, 16'h0000, 1, 16'h9999); chk_bus("s6_post", 1, 16'h0000, 1, 0);
    chk_data("s6_post", 16'h9999, 16'h0002); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
